// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - framed one-bit-per-clock serial transmitter with valid/ready word intake
// Optional even parity bit between data and stop is enabled by defining SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             c,
  input  logic             r,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             q,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             head;
  logic [WIDTH-1:0] sh_shift;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic             par;
`endif

  // The bit at the head of the shift register is always the next one to put on q.
  always_comb begin
    head     = (MSB_FIRST != 0) ? sh[WIDTH-1] : sh[0];
    sh_shift = (MSB_FIRST != 0) ? (sh << 1) : (sh >> 1);
  end

  always_ff @(posedge c) begin
    if (r) begin
      state <= IDLE;
      q     <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sh    <= '0;
      cnt   <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, STOP: begin
          if (valid) begin
            state <= START;
            sh    <= data;
            cnt   <= '0;
            q     <= 1'b1;
            ready <= 1'b0;
            busy  <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par   <= ^data;
`endif
          end else begin
            state <= IDLE;
            q     <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        START: begin
          state <= DATA;
          q     <= head;
          sh    <= sh_shift;
        end
        DATA: begin
          if (cnt == LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state <= PARITY;
            q     <= par;
`else
            state <= STOP;
            q     <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b1;
`endif
          end else begin
            q   <= head;
            sh  <= sh_shift;
            cnt <= cnt + 1'b1;
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY: begin
          state <= STOP;
          q     <= 1'b0;
          ready <= 1'b1;
          done  <= 1'b1;
        end
`endif
        default: begin
          state <= IDLE;
          q     <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmit-side companion to the single-bit capture flop: turns parallel words into a framed, one-bit-per-clock serial stream on `q`.
- A downstream D-FF, or a chain of them, samples `q` on the same clock edge.
- Words are accepted on a valid/ready handshake.
- Idle line level is 0, matching the flop's initial state, so a capture chain sees a clean idle before the first start bit.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.
- MSB_FIRST, 0, data bit order: 0 = bit 0 sent first, 1 = bit WIDTH-1 sent first.

Ports:
- c  input  1  clock; all state updates on posedge c.
- r  input  1  reset; synchronous, active-high.
- data  input  WIDTH  word to transmit; sampled only on an accepting edge.
- valid  input  1  data is offered.
- ready  output  1  block will accept data at the next posedge where valid=1.
- q  output  1  serial line, registered.
- busy  output  1  a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse while the stop bit is on q.

Behaviour:
- Interface: one clock `c`; reset `r` is synchronous and active-high. At a posedge with r=1, all state is reset regardless of the other inputs.
- Reset values: state=IDLE, q=0, ready=1, busy=0, done=0, shift register=0, bit counter=0.
- Frame format, in order:
  - Start bit: 1.
  - WIDTH data bits, in the order set by MSB_FIRST.
  - Optional parity bit (see Optional Feature).
  - Stop bit: 0.
- Frame length is WIDTH+2 cycles, or WIDTH+3 with parity.
- States:
  - IDLE: q=0.
  - START: q=1.
  - DATA: q = current data bit.
  - PARITY: only when the feature is compiled in.
  - STOP: q=0, done=1.
- Outputs are registered and reflect the current state.
- Accept: a posedge with valid=1 and ready=1 captures data into the shift register, clears the bit counter, and moves to START. q=1 from that edge on.
- Latency: the start bit appears on q one edge after the data is presented, i.e. q changes at the accepting edge itself.
- START to DATA after 1 cycle. DATA lasts exactly WIDTH cycles; the counter runs 0..WIDTH-1. Shift direction follows MSB_FIRST.
- DATA ends at counter = WIDTH-1: next state is PARITY if compiled in, else STOP. PARITY to STOP after 1 cycle.
- ready=1 in IDLE and STOP only; 0 in START, DATA and PARITY.
- STOP exit:
  - valid=1 at the STOP edge: the next word is accepted and the next state is START. Back-to-back frames have no idle gap; the stop bit is always exactly 1 cycle.
  - valid=0 at the STOP edge: next state is IDLE.
- valid while ready=0 is ignored: no capture, no error. The source holds valid/data until accepted.
- Changes to data after the accepting edge do not affect the frame in flight.
- Reset mid-frame aborts the frame: q=0 at that edge, no done pulse, and the partial frame is discarded.
- busy=1 in START, DATA, PARITY and STOP.
- Counter width is $clog2(WIDTH). There is no wrap-around beyond WIDTH-1 because the counter is cleared on accept.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - q = XOR of all WIDTH captured data bits (even parity: the total number of 1s over data+parity is even).
  - Parity is computed from the word captured at accept, not from the live data input.
  - Frame is WIDTH+3 cycles; ready=0 during PARITY.
- Undefined: no PARITY state, no parity logic synthesized, frame is WIDTH+2 cycles.

Test Plan:
1. Reset, then hold valid=0 for 10 cycles -> q=0, ready=1, busy=0, done=0 throughout.
2. WIDTH=8, MSB_FIRST=0, single word 0xA5, no parity -> q from the accepting edge: 1, 1,0,1,0,0,1,0,1, 0, then idle 0. done high only in the stop cycle. ready low for the 9 cycles from START through the last data bit.
3. MSB_FIRST=1, word 0xA5 -> data bits on q are 1,0,1,0,0,1,0,1, framed 1…0. Repeat with 0x01 -> data bits 0,0,0,0,0,0,0,1.
4. Back-to-back: valid held high with 0x0F then 0xF0 -> second start bit directly after the first stop bit, with no idle cycle. Total 20 cycles; busy stays 1 throughout.
5. Reset asserted in the 4th data cycle of 0xFF -> q=0 and state IDLE at that edge, no done pulse. A following 0x3C transmits correctly.
6. With SERIAL_FRAME_TX_PARITY_EN defined, words 0x07 and 0xA5 -> parity bits 1 and 0 respectively. Frames are 11 cycles each.
